// File: rtl/ad7873_ctrl_pkg.sv
// rtl/ad7873_ctrl_pkg.sv - AD7873 command fields, frame constants and FSM state type
package ad7873_ctrl_pkg;

    localparam logic       CMD_START_BIT   = 1'b1;
    localparam logic       MODE_12BIT      = 1'b0;
    localparam logic [1:0] PD_AUTO_PWRDN   = 2'b00;
    localparam logic [1:0] PD_ALWAYS_ON    = 2'b11;

    localparam int FRAME_LEN       = 24;
    localparam int FIRST_DATA_EDGE = 10;
    localparam int LAST_DATA_EDGE  = 21;
    localparam int BUSY_FIRST_EDGE = 8;
    localparam int BUSY_CHECK_EDGE = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP
    } state_t;

    function automatic logic [7:0] make_cmd(input logic [2:0] chan,
                                            input logic       ser_dfr,
                                            input logic [1:0] pd);
        return {CMD_START_BIT, chan, MODE_12BIT, ser_dfr, pd};
    endfunction

endpackage

// File: rtl/ad7873_ctrl_if.sv
// rtl/ad7873_ctrl_if.sv - host request/result and ADC serial signals of the AD7873 controller
interface ad7873_ctrl_if;

    logic        start;
    logic [2:0]  chan;
    logic        ready;
    logic [11:0] data;
    logic        valid;
    logic        dclk;
    logic        din;
    logic        csb;
    logic        dout;
    logic        busy;

    modport slave (
        input  start, chan, dout, busy,
        output ready, data, valid, dclk, din, csb
    );

    modport master (
        output start, chan, dout, busy,
        input  ready, data, valid, dclk, din, csb
    );

endinterface

// File: rtl/ad7873_dclk_gen.sv
// rtl/ad7873_dclk_gen.sv - dclk divider: low half then high half, with rise/fall strobes
module ad7873_dclk_gen #(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic rstb,
    input  logic en_i,
    output logic dclk_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    logic [7:0] cnt_q;
    logic       dclk_q;
    logic       edge_due;

    // Strobes flag the clk edge on which dclk is about to toggle.
    assign edge_due    = en_i && (cnt_q == 8'(HALF_DIV - 1));
    assign rise_tick_o = edge_due && !dclk_q;
    assign fall_tick_o = edge_due && dclk_q;
    assign dclk_o      = dclk_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q  <= '0;
            dclk_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q  <= '0;
            dclk_q <= 1'b0;
        end else if (edge_due) begin
            cnt_q  <= '0;
            dclk_q <= !dclk_q;
        end else begin
            cnt_q  <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/ad7873_ctrl.sv
// rtl/ad7873_ctrl.sv - AD7873 touch-screen ADC controller: one 24-dclk frame per accepted start
module ad7873_ctrl
    import ad7873_ctrl_pkg::*;
#(
    parameter int         HALF_DIV = 4,
    parameter logic [1:0] PD       = PD_ALWAYS_ON,
    parameter logic       SER_DFR  = 1'b0,
    parameter int         IDLE_GAP = 8
) (
    input  logic          clk,
    input  logic          rstb,
    ad7873_ctrl_if.slave  bus
);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [4:0]  bit_cnt_q;
    logic [4:0]  edge_idx;
    logic [7:0]  cmd_q;
    logic [11:0] shift_q;
    logic [11:0] data_q;
    logic        csb_q, din_q, valid_q, ready_q;
    logic        busy_q, busy_seen_q;
    logic        dclk, rise_tick, fall_tick;

    ad7873_dclk_gen #(.HALF_DIV(HALF_DIV)) u_dclk_gen (
        .clk         (clk),
        .rstb        (rstb),
        .en_i        (state_q == ST_SHIFT),
        .dclk_o      (dclk),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick)
    );

    assign edge_idx = bit_cnt_q + 5'd1;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            cmd_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            csb_q       <= 1'b1;
            din_q       <= 1'b0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            busy_seen_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            busy_q  <= bus.busy;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && ready_q) begin
                        cmd_q       <= make_cmd(bus.chan, SER_DFR, PD);
                        cnt_q       <= '0;
                        bit_cnt_q   <= '0;
                        busy_seen_q <= 1'b0;
                        ready_q     <= 1'b0;
                        state_q     <= ST_SETUP;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    // First SETUP cycle drops csb and presents the command MSB.
                    if (csb_q) begin
                        csb_q <= 1'b0;
                        din_q <= cmd_q[7];
                    end else if (cnt_q == 16'(HALF_DIV - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_SHIFT: begin
                    if (rise_tick) begin
                        bit_cnt_q <= edge_idx;
                        if (edge_idx >= 5'(FIRST_DATA_EDGE) && edge_idx <= 5'(LAST_DATA_EDGE))
                            shift_q <= {shift_q[10:0], bus.dout};
                        // busy is advisory only; the frame never waits on it.
                        if (edge_idx >= 5'(BUSY_FIRST_EDGE) && edge_idx <= 5'(BUSY_CHECK_EDGE))
                            busy_seen_q <= busy_seen_q | busy_q;
                    end
                    if (fall_tick) begin
                        if (bit_cnt_q == 5'(FRAME_LEN)) begin
                            csb_q   <= 1'b1;
                            din_q   <= 1'b0;
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= ST_GAP;
                        end else begin
                            din_q <= cmd_q[6];
                            cmd_q <= {cmd_q[6:0], 1'b0};
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_q == 16'(IDLE_GAP - 1)) begin
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.csb   = csb_q;
    assign bus.dclk  = dclk;
    assign bus.din   = din_q;
    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_ad7873_ctrl.sv
// tb/tb_ad7873_ctrl.sv - directed self-checking bench for ad7873_ctrl with a behavioural ADC
module tb_ad7873_ctrl;

    localparam int HALF_DIV = 2;
    localparam int IDLE_GAP = 8;

    logic clk = 1'b0;
    logic rstb;

    ad7873_ctrl_if u_if();

    ad7873_ctrl #(
        .HALF_DIV (HALF_DIV),
        .PD       (2'b11),
        .SER_DFR  (1'b0),
        .IDLE_GAP (IDLE_GAP)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (u_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int rise_cnt = 0, fall_cnt = 0, din_err = 0;
    int valid_cnt = 0, frame_cnt = 0, high_run = 0, last_gap = 0;
    logic [7:0]  cmd_byte = '0;
    logic [11:0] adc_result = '0;
    logic        busy_en = 1'b1;
    logic        csb_prev = 1'b1;
    logic        dclk_prev = 1'b0;

    function automatic logic [11:0] adc_model(input logic [2:0] c);
        case (c)
            3'b101:  return 12'd370;
            3'b001:  return 12'd192;
            3'b011:  return 12'd500;
            default: return 12'hA5C ^ {9'd0, c};
        endcase
    endfunction

    // ADC model and bus monitor, evaluated away from the active clk edge.
    always @(negedge clk) begin
        if (u_if.valid === 1'b1) valid_cnt++;
        if (u_if.csb === 1'b1) begin
            high_run++;
        end else begin
            if (high_run > 0) last_gap = high_run;
            high_run = 0;
        end
        if (csb_prev && !u_if.csb) begin
            rise_cnt = 0;
            fall_cnt = 0;
            din_err  = 0;
            frame_cnt++;
        end
        if (!u_if.csb && u_if.dclk && !dclk_prev) begin
            rise_cnt++;
            if (rise_cnt <= 8) cmd_byte = {cmd_byte[6:0], u_if.din};
            else if (u_if.din !== 1'b0) din_err++;
        end
        if (!u_if.csb && !u_if.dclk && dclk_prev) begin
            fall_cnt++;
            if (fall_cnt == 8) adc_result = adc_model(cmd_byte[6:4]);
            if (fall_cnt >= 9 && fall_cnt <= 20) u_if.dout = adc_result[20 - fall_cnt];
            else u_if.dout = 1'b0;
            u_if.busy = busy_en && (fall_cnt == 7 || fall_cnt == 8);
        end
        csb_prev  = u_if.csb;
        dclk_prev = u_if.dclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [2:0] c);
        @(negedge clk);
        u_if.chan  = c;
        u_if.start = 1'b1;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (u_if.valid !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_valid_seen"}, 32'(u_if.valid), 32'd1);
    endtask

    int n, v0, f0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb       = 1'b0;
        u_if.start = 1'b0;
        u_if.chan  = 3'b000;
        repeat (3) @(negedge clk);
        check("rst_csb",   32'(u_if.csb),   32'd1);
        check("rst_dclk",  32'(u_if.dclk),  32'd0);
        check("rst_din",   32'(u_if.din),   32'd0);
        check("rst_valid", 32'(u_if.valid), 32'd0);
        check("rst_ready", 32'(u_if.ready), 32'd0);
        check("rst_data",  32'(u_if.data),  32'd0);
        rstb = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(u_if.ready), 32'd1);

        // Single frame, chan 101
        v0 = valid_cnt;
        launch(3'b101);
        check("t1_ready_low", 32'(u_if.ready), 32'd0);
        wait_valid("t1", n);
        check("t1_latency", 32'(n), 32'd99);
        check("t1_data", 32'(u_if.data), 32'd370);
        check("t1_cmd", 32'(cmd_byte), 32'hD3);
        check("t1_rises", 32'(rise_cnt), 32'd24);
        check("t1_din_zero_tail", 32'(din_err), 32'd0);
        @(posedge clk);
        #1;
        check("t1_valid_pulse", 32'(u_if.valid), 32'd0);
        check("t1_csb_idle", 32'(u_if.csb), 32'd1);
        check("t1_dclk_idle", 32'(u_if.dclk), 32'd0);
        check("t1_din_idle", 32'(u_if.din), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("t1_valid_count", 32'(valid_cnt - v0), 32'd1);
        check("t1_data_hold", 32'(u_if.data), 32'd370);

        // Back-to-back with start held high
        f0 = frame_cnt;
        @(negedge clk);
        u_if.chan  = 3'b001;
        u_if.start = 1'b1;
        @(posedge clk);
        #1;
        wait_valid("b2b1", n);
        check("b2b1_latency", 32'(n), 32'd99);
        check("b2b1_data", 32'(u_if.data), 32'd192);
        @(negedge clk);
        u_if.chan = 3'b011;
        repeat (40) @(posedge clk);
        #1;
        check("b2b_data_hold", 32'(u_if.data), 32'd192);
        check("b2b_second_running", 32'(u_if.csb), 32'd0);
        wait_valid("b2b2", n);
        u_if.start = 1'b0;
        check("b2b2_data", 32'(u_if.data), 32'd500);
        check("b2b_gap", 32'(last_gap >= IDLE_GAP), 32'd1);
        repeat (30) @(posedge clk);
        #1;
        check("b2b_frames", 32'(frame_cnt - f0), 32'd2);

        // Starts during SHIFT and GAP are ignored
        v0 = valid_cnt;
        f0 = frame_cnt;
        launch(3'b010);
        repeat (30) @(posedge clk);
        @(negedge clk);
        u_if.chan  = 3'b111;
        u_if.start = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
        wait_valid("ign", n);
        check("ign_data", 32'(u_if.data), 32'hA5E);
        repeat (2) @(negedge clk);
        u_if.start = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        check("ign_valid_count", 32'(valid_cnt - v0), 32'd1);
        check("ign_frame_count", 32'(frame_cnt - f0), 32'd1);
        check("ign_csb_high", 32'(u_if.csb), 32'd1);

        // Reset during the high phase of period 15
        launch(3'b101);
        n = 0;
        @(negedge clk);
        while ((fall_cnt < 14 || u_if.dclk !== 1'b1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_dclk_high", 32'(u_if.dclk), 32'd1);
        v0   = valid_cnt;
        rstb = 1'b0;
        #1;
        check("rst_mid_csb", 32'(u_if.csb), 32'd1);
        check("rst_mid_dclk", 32'(u_if.dclk), 32'd0);
        check("rst_mid_valid", 32'(u_if.valid), 32'd0);
        check("rst_mid_data", 32'(u_if.data), 32'd0);
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        repeat (150) @(posedge clk);
        #1;
        check("rst_mid_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("rst_mid_ready", 32'(u_if.ready), 32'd1);
        launch(3'b011);
        wait_valid("post_rst", n);
        check("post_rst_latency", 32'(n), 32'd99);
        check("post_rst_data", 32'(u_if.data), 32'd500);

        // busy held low for the whole frame
        busy_en = 1'b0;
        repeat (12) @(posedge clk);
        launch(3'b101);
        wait_valid("nobusy", n);
        check("nobusy_latency", 32'(n), 32'd99);
        check("nobusy_data", 32'(u_if.data), 32'd370);

        repeat (12) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad7873_ctrl.md
AD7873_CTRL -- requirements
Module: ad7873_ctrl

Interface
REQ-001 Parameter HALF_DIV, default 4: clk cycles per dclk half-period; legal range 2..255.
REQ-002 Parameter PD, default 2'b11: PD1:PD0 bits placed in every command byte.
REQ-003 Parameter SER_DFR, default 1'b0: SER/DFR bit placed in every command byte.
REQ-004 Parameter IDLE_GAP, default 8: minimum clk cycles csb stays high between frames.
REQ-005 Port clk, input, 1: single system clock; all logic is on the rising edge.
REQ-006 Port rstb, input, 1: asynchronous, active-low reset.
REQ-007 Port start, input, 1: conversion request, sampled only in IDLE.
REQ-008 Port chan, input, 3: A2:A0 channel select, captured when start is accepted.
REQ-009 Port ready, output, 1: high only in IDLE.
REQ-010 Port data, output, 12: last conversion result, MSB first as received.
REQ-011 Port valid, output, 1: one-clk pulse when data updates.
REQ-012 Ports dclk (out, 1), din (out, 1), csb (out, 1): serial clock, command data and active-low chip select to the ADC.
REQ-013 Ports dout (in, 1) and busy (in, 1): ADC serial data and conversion-busy flag.

Function
REQ-014 Command byte: {1'b1, chan, 1'b0 (12-bit mode), SER_DFR, PD}, shifted MSB first.
REQ-015 FSM states: IDLE, SETUP, SHIFT, GAP.
- IDLE -> SETUP on start; chan is latched, and csb falls on the next clk edge.
REQ-016 SETUP lasts HALF_DIV clk cycles with dclk low, then the FSM enters SHIFT.
REQ-017 SHIFT runs exactly 24 dclk periods of 2*HALF_DIV clk each.
- dclk is low for the first half of each period and high for the second half.
REQ-018 Drive din only on dclk falling-edge instants, including the SETUP entry.
- Periods 1-8 carry command bits 7..0.
- Periods 9-24 carry din=0.
REQ-019 Sample dout on the clk cycle that raises dclk. Rising edges 10..21 capture result bits 11..0.
- Rising edges 1-9 and 22-24 are ignored.
REQ-020 The busy input is not required for sequencing.
- It is registered and checked at rising edge 9.
- If busy was never seen high during periods 8-9, the frame still completes and data is still updated.
REQ-021 After the 24th high phase, dclk returns low, csb rises, and the FSM enters GAP.
- data updates and valid pulses on the same clk edge that csb rises.
REQ-022 GAP holds csb high for IDLE_GAP clk cycles, then the FSM returns to IDLE.
REQ-023 start asserted outside IDLE is ignored, with no queuing.
- start held high in IDLE launches back-to-back frames, each separated by GAP.
REQ-024 Latency from start accepted to valid = 1 + HALF_DIV + 48*HALF_DIV clk cycles.
REQ-025 dclk idles low, and din idles 0 whenever csb is high.
REQ-026 data holds its value between valid pulses.

Reset
REQ-027 When rstb is low, outputs are forced immediately: csb=1, dclk=0, din=0, valid=0, ready=0, data=0, state=IDLE, all counters 0.
REQ-028 Reset asserted mid-frame aborts the frame with no valid pulse.
- After rstb releases, the first accepted frame starts clean at SETUP.
REQ-029 ready rises on the first clk edge after rstb deasserts.

Structure
REQ-030 Command-field constants live in the shared AD7873 defines/package: start bit, mode bits, PD codes, frame length 24, first and last data edge indices.
REQ-031 One sub-module, ad7873_dclk_gen, owns the dclk divider.
- It takes an enable and HALF_DIV.
- It outputs dclk plus one-clk rise_tick and fall_tick strobes.
REQ-032 The FSM, bit counter (0..24) and 12-bit shift register live in ad7873_ctrl.

Verification
REQ-033 Bench ADC model returns 12'd370 for chan=3'b101 (PD=11). Start with chan=101 -> din byte 8'hD3 on periods 1-8, data=12'd370, one valid pulse.
REQ-034 chan=001 then chan=011 back-to-back, start held high -> data 12'd192 then 12'd500.
- csb stays high for at least IDLE_GAP between the two frames.
REQ-035 HALF_DIV=2: count clk cycles from start to valid -> exactly 99.
- dclk shows 24 rising edges while csb is low.
REQ-036 rstb pulsed low during period 15 -> csb=1 and dclk=0 within the same cycle, with no valid pulse.
- A new start afterwards -> correct result.
REQ-037 start pulsed during SHIFT and during GAP -> ignored, with exactly one valid pulse per accepted start.
REQ-038 The bench holds busy stuck low -> the frame still completes, and data reflects the sampled dout bits.
